// File: rtl/uart_byte_tx.sv
`timescale 1ns / 1ps
// uart_byte_tx
//   Single-byte UART transmitter. It sends 8N1 frames and the baud rate is
//   selected at runtime. A byte and a baud code are latched when Send_en is
//   seen in IDLE. The frame is then shifted out LSB first on uart_tx, and
//   Tx_done pulses for one clock during the last cycle of the stop bit.
//   Holding Send_en high chains frames with no idle gap.
//
//   Optional build macro: UART_TX_PARITY_EN
//     When defined, an even-parity slot is inserted between Data[7] and the
//     stop bit. The frame is then 11 slots long.
//
// Ports
//   Clk       in   system clock, rising edge
//   Reset_n   in   asynchronous reset, active HIGH (legacy name)
//   Data      in   [7:0] byte to send, latched at frame start
//   Send_en   in   level request to transmit
//   Baud_set  in   [2:0] baud select, latched at frame start
//                  0:9600 1:19200 2:38400 3:57600 4:115200 5-7:9600
//   uart_tx   out  serial line, idle high, registered
//   Tx_done   out  one-cycle pulse on the last cycle of the stop bit
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, waiting for Send_en
// SEND  | shifting slots: start, D0..D7, [parity], stop
module uart_byte_tx #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Data,
  input  logic       Send_en,
  input  logic [2:0] Baud_set,
  output logic       uart_tx,
  output logic       Tx_done
);

  localparam int DIV_W = $clog2(CLK_FREQ / 9600 + 1);

`ifdef UART_TX_PARITY_EN
  localparam logic [3:0] LAST_SLOT = 4'd10;
`else
  localparam logic [3:0] LAST_SLOT = 4'd9;
`endif

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_TWO = DIV_W'(2);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       baud_q, baud_d;
  logic             uart_tx_q, uart_tx_d;
  logic             tx_done_q, tx_done_d;
  logic [DIV_W-1:0] period;
  logic             start;

  // Line level for a given slot of the latched byte.
  function automatic logic slot_level(input logic [3:0] idx, input logic [7:0] d);
    if (idx == 4'd0) begin
      return 1'b0;
    end else if (idx <= 4'd8) begin
      return d[3'(idx - 4'd1)];
`ifdef UART_TX_PARITY_EN
    end else if (idx == 4'd9) begin
      return ^d;
`endif
    end else begin
      return 1'b1;
    end
  endfunction

  // The bit period is decoded from the latched code, so Baud_set changes
  // during a frame have no effect.
  always_comb begin
    case (baud_q)
      3'd1:    period = DIV_W'(CLK_FREQ / 19200);
      3'd2:    period = DIV_W'(CLK_FREQ / 38400);
      3'd3:    period = DIV_W'(CLK_FREQ / 57600);
      3'd4:    period = DIV_W'(CLK_FREQ / 115200);
      default: period = DIV_W'(CLK_FREQ / 9600);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    div_d     = div_q;
    data_d    = data_q;
    baud_d    = baud_q;
    uart_tx_d = uart_tx_q;
    tx_done_d = 1'b0;
    start     = 1'b0;

    case (state_q)
      IDLE: begin
        uart_tx_d = 1'b1;
        start     = Send_en;
      end
      SEND: begin
        if (div_q == period - DIV_ONE) begin
          div_d = '0;
          if (bit_q == LAST_SLOT) begin
            state_d   = IDLE;
            bit_d     = 4'd0;
            uart_tx_d = 1'b1;
            // A request still present here starts the next frame straight
            // after the stop bit.
            start     = Send_en;
          end else begin
            bit_d     = bit_q + 4'd1;
            uart_tx_d = slot_level(bit_q + 4'd1, data_q);
          end
        end else begin
          div_d = div_q + DIV_ONE;
          // Tx_done is registered, so it is raised one cycle early. That
          // makes it coincide with the final cycle of the stop bit.
          if ((bit_q == LAST_SLOT) && (div_q == period - DIV_TWO)) begin
            tx_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        uart_tx_d = 1'b1;
      end
    endcase

    if (start) begin
      state_d   = SEND;
      bit_d     = 4'd0;
      div_d     = '0;
      data_d    = Data;
      baud_d    = Baud_set;
      uart_tx_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset_n) begin
    if (Reset_n) begin
      state_q   <= IDLE;
      bit_q     <= 4'd0;
      div_q     <= '0;
      data_q    <= 8'h00;
      baud_q    <= 3'd0;
      uart_tx_q <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      data_q    <= data_d;
      baud_q    <= baud_d;
      uart_tx_q <= uart_tx_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign uart_tx = uart_tx_q;
  assign Tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
`timescale 1ns / 1ps
// Testbench for uart_byte_tx: table-driven directed frames, hand-written
// reset/baud corner sequences, and random back-to-back frames checked
// against a slot-level reference model of the UART frame.
module tb_uart_byte_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] Data;
  logic       Send_en;
  logic [2:0] Baud_set;
  logic       uart_tx;
  logic       Tx_done;

  int n_vec = 0;
  int n_err = 0;

  uart_byte_tx #(.CLK_FREQ(50000000)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Data     (Data),
    .Send_en  (Send_en),
    .Baud_set (Baud_set),
    .uart_tx  (uart_tx),
    .Tx_done  (Tx_done)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] baud;
    int         exp_period;
    int         idle_after;
  } vec_t;

  vec_t vecs[3];

  // Bit period: clock frequency over the selected baud rate.
  function automatic int ref_period(input logic [2:0] b);
    int rates[5] = '{9600, 19200, 38400, 57600, 115200};
    if (b > 3'd4) return 50000000 / rates[0];
    return 50000000 / rates[b];
  endfunction

  // Expected line level in frame slot s.
  function automatic logic ref_bit(input logic [7:0] d, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return d[s-1];
`ifdef UART_TX_PARITY_EN
    if (s == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input int n, input string name);
    int err = 0;
    repeat (n) begin
      @(negedge Clk);
      if (uart_tx !== 1'b1 || Tx_done !== 1'b0) err++;
    end
    check(name, err, 0);
  endtask

  // Called between a negedge and the start edge, with Send_en=1 and the DUT
  // ready to start. Samples every cycle of the frame. Data and Baud_set are
  // scrambled mid-frame. On the Tx_done cycle, Send_en/Data/Baud_set are set
  // for whatever follows.
  task automatic check_frame(input logic [7:0] d, input int p, input bit keep,
                             input logic [7:0] nd, input logic [2:0] nb);
    int slot_err[NSLOT];
    int done_cnt = 0;
    int done_last = 0;
    int s;
    for (int i = 0; i < NSLOT; i++) slot_err[i] = 0;
    for (int c = 0; c < NSLOT * p; c++) begin
      @(negedge Clk);
      s = c / p;
      if (uart_tx !== ref_bit(d, s)) slot_err[s]++;
      if (Tx_done === 1'b1) done_cnt++;
      if (c == 4 * p + 7) begin
        Data     = 8'($urandom);
        Baud_set = 3'($urandom);
      end
      if (c == NSLOT * p - 1) begin
        done_last = (Tx_done === 1'b1) ? 1 : 0;
        Send_en   = keep;
        Data      = nd;
        Baud_set  = nb;
      end
    end
    for (int i = 0; i < NSLOT; i++)
      check($sformatf("frame %02h slot %0d bad cycles", d, i), slot_err[i], 0);
    check($sformatf("frame %02h Tx_done pulse count", d), done_cnt, 1);
    check($sformatf("frame %02h Tx_done on last stop cycle", d), done_last, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] r[3];
    int low;

    vecs[0] = '{data: 8'h57, baud: 3'd4, exp_period: 434,  idle_after: 1000};
    vecs[1] = '{data: 8'h75, baud: 3'd4, exp_period: 434,  idle_after: 200};
    vecs[2] = '{data: 8'hA5, baud: 3'd0, exp_period: 5208, idle_after: 200};

    Reset_n  = 1'b1;
    Send_en  = 1'b0;
    Data     = 8'h00;
    Baud_set = 3'd0;
    #100;
    check("reset uart_tx", int'(uart_tx), 1);
    check("reset Tx_done", int'(Tx_done), 0);
    #101;
    Reset_n = 1'b0;
    @(negedge Clk);
    check_idle(50, "idle after reset");

    foreach (vecs[i]) begin
      Data     = vecs[i].data;
      Baud_set = vecs[i].baud;
      Send_en  = 1'b1;
      check_frame(vecs[i].data, vecs[i].exp_period, 1'b0, 8'h00, 3'd0);
      check_idle(vecs[i].idle_after, $sformatf("idle after frame %02h", vecs[i].data));
    end

    // Baud_set=7 falls back to 9600: measure the start bit, then abort.
    Data     = 8'h01;
    Baud_set = 3'd7;
    Send_en  = 1'b1;
    low      = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge Clk);
      if (uart_tx === 1'b0) low++;
      else break;
    end
    check("baud 7 start bit width", low, ref_period(3'd7));
    Send_en = 1'b0;
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b0;
    check_idle(50, "idle after baud 7 abort");

    // Reset during data bit 3, then a fresh frame with Send_en held.
    Data     = 8'h57;
    Baud_set = 3'd4;
    Send_en  = 1'b1;
    repeat (4 * 434 + 200) @(negedge Clk);
    check("line low in data bit 3 before reset", int'(uart_tx), 0);
    Data    = 8'hC3;
    Reset_n = 1'b1;
    #1;
    check("async reset uart_tx", int'(uart_tx), 1);
    check("async reset Tx_done", int'(Tx_done), 0);
    check_idle(20, "held in reset");
    Reset_n = 1'b0;
    check_frame(8'hC3, 434, 1'b0, 8'h00, 3'd0);
    check_idle(200, "idle after fresh frame");

    // Random back-to-back frames with Send_en held high.
    foreach (r[i]) r[i] = 8'($urandom);
    Data     = r[0];
    Baud_set = 3'd4;
    Send_en  = 1'b1;
    check_frame(r[0], ref_period(3'd4), 1'b1, r[1], 3'd4);
    check_frame(r[1], ref_period(3'd4), 1'b1, r[2], 3'd4);
    check_frame(r[2], ref_period(3'd4), 1'b0, 8'h00, 3'd0);
    check_idle(200, "idle after back-to-back");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Single-byte UART transmitter with 8N1 framing and a runtime-selectable baud rate.
- A parallel byte from upstream logic is serialised onto the uart_tx line.
- Completion is signalled with a one-cycle Tx_done pulse.
- Sits between a byte source (command/test logic) and the FPGA TX pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz. Sets the bit-period divider: bit period = CLK_FREQ/baud cycles, using integer division.

Ports:
- Clk  input  1  system clock (50 MHz nominal); all logic on the rising edge.
- Reset_n  input  1  reset, asynchronous and active-high (asserted when 1). The port name keeps the codebase spelling.
- Data  input  8  byte to transmit; sampled when a frame starts.
- Send_en  input  1  level request to transmit.
- Baud_set  input  3  baud select; sampled when a frame starts.
- uart_tx  output  1  serial line; idle high.
- Tx_done  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset (async, Reset_n=1):
  - uart_tx=1, Tx_done=0.
  - State IDLE; bit and divider counters cleared.
  - A reset mid-frame aborts the frame immediately; the line returns high.
- Baud_set map (bit period in cycles at 50 MHz):
  - 0=9600 (5208), 1=19200 (2604), 2=38400 (1302), 3=57600 (868), 4=115200 (434).
  - 5, 6 and 7 fall back to 9600.
- States:
  - IDLE: uart_tx=1. When Send_en=1 at a clock edge, latch Data and Baud_set, go to SEND. uart_tx drives the start bit 0 from that edge, so latency is 1 clock.
  - SEND: 10 bit slots, each exactly one bit period long.
    - Slot 0 = start (0).
    - Slots 1-8 = Data[0]..Data[7], LSB first.
    - Slot 9 = stop (1).
    - The divider counts 0..period-1; the bit index advances at period-1.
  - At the last cycle of the stop slot:
    - Tx_done=1 for exactly one clock.
    - State returns to IDLE; uart_tx remains 1.
- Handshake and boundary conditions:
  - Once started, a frame always completes. Deasserting Send_en mid-frame does not abort it.
  - Changes to Data or Baud_set during a frame are ignored, because the latched copies are used.
  - If Send_en is still 1 in the cycle after Tx_done, a new frame starts with a new latch and its start bit follows immediately. This gives back-to-back frames with no idle gap beyond one stop bit.
  - If Send_en is already 0 at that edge, the line stays idle.
- Outputs are registered with no combinational path from inputs, so uart_tx is glitch-free.
- Total frame length = 10 × period cycles (4340 cycles at Baud_set=4).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the latched Data) is inserted after Data[7] and before the stop bit.
  - The frame becomes 11 slots.
  - Tx_done is still asserted on the last cycle of the stop bit (11 × period cycles after start).
- Undefined: plain 8N1 as above. No parity logic is synthesised.

Test Plan:
- Reset held 201 ns, then released → uart_tx=1, Tx_done=0 throughout reset and idle.
- Baud_set=4, Data=0x57, Send_en=1.
  - uart_tx sequence, each bit 434 cycles (8.68 us): 0, 1,1,1,0,1,0,1,0, 1.
  - Tx_done pulses once, 1 cycle wide, 4340 cycles after start.
  - Send_en dropped on that pulse → line stays high.
- After 20 us idle, Data=0x75 → bits 0, 1,0,1,0,1,1,1,0, 1 with identical timing; single Tx_done pulse.
- Baud_set=0, Data=0xA5 → each bit 5208 cycles. Baud_set=7 gives the same 5208-cycle timing.
  - Changing Data or Baud_set mid-frame does not alter the waveform.
- Send_en held high continuously → back-to-back frames: a start bit directly follows each stop bit, with one Tx_done per frame.
- Reset asserted mid-frame (during data bit 3) → uart_tx=1 immediately and no Tx_done. After release with Send_en=1, a complete fresh frame is sent.
